lcd_fb_arbiter: RTL and testbench

LCD_FB_ARBITER -- requirements
Module: lcd_fb_arbiter

---
 rtl/lcd_fb_arbiter_if.sv | 42 ++++
 rtl/lcd_fb_arbiter.sv | 145 ++++++++++++++
 tb/tb_lcd_fb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_fb_arbiter_if.sv
// Bundle of the LCD refresh port, CPU access port and single-port RAM port
// that the framebuffer arbiter sits between.
interface lcd_fb_arbiter_if;
    logic        lcd_req;
    logic [13:0] lcd_addr;
    logic [7:0]  lcd_data;
    logic        lcd_valid;

    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;

    logic        ram_en;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    // Arbiter side.
    modport slave (
        input  lcd_req, lcd_addr,
        output lcd_data, lcd_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    // Requesters plus RAM side.
    modport master (
        output lcd_req, lcd_addr,
        input  lcd_data, lcd_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/lcd_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port RAM between LCD refresh reads
// and CPU accesses with fixed 3-cycle access latency and CPU starvation limit.
module lcd_fb_arbiter #(
    parameter int unsigned RES_X      = 320,
    parameter int unsigned RES_Y      = 240,
    parameter int unsigned FB_BYTES   = RES_X * RES_Y / 8,
    parameter int unsigned STARVE_MAX = 15
) (
    input logic             clk,
    input logic             rst,
    lcd_fb_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE_LCD = 3'd1,
        ISSUE_CPU = 3'd2,
        RESP_LCD  = 3'd3,
        RESP_CPU  = 3'd4,
        CPU_ERR   = 3'd5
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_d;
    logic [3:0]  starve_cnt, starve_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;

    logic        cpu_win;
    logic        cpu_oob;

    logic [7:0]  lcd_data_o;
    logic        lcd_valid_o;
    logic [7:0]  cpu_rdata_o;
    logic        cpu_ack_o;
    logic        cpu_err_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [13:0] ram_addr_o;
    logic [7:0]  ram_wdata_o;

    assign cpu_win = bus.cpu_req && (!bus.lcd_req || (starve_cnt == STARVE_LIM));
    assign cpu_oob = (32'(bus.cpu_addr) >= FB_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    // Outputs are decoded from the state register, so every strobe is exactly
    // one cycle wide and all outputs read as zero in IDLE (and after reset).
    always_comb begin
        state_d     = state;
        starve_d    = starve_cnt;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        lcd_data_o  = '0;
        lcd_valid_o = 1'b0;
        cpu_rdata_o = '0;
        cpu_ack_o   = 1'b0;
        cpu_err_o   = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;

        unique case (state)
            IDLE: begin
                if (!bus.cpu_req) begin
                    starve_d = '0;
                end
                if (cpu_win) begin
                    starve_d = '0;
                    addr_d   = bus.cpu_addr;
                    wdata_d  = bus.cpu_wdata;
                    we_d     = bus.cpu_we;
                    state_d  = cpu_oob ? CPU_ERR : ISSUE_CPU;
                end else if (bus.lcd_req) begin
                    addr_d  = bus.lcd_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    state_d = ISSUE_LCD;
                    if (bus.cpu_req && (starve_cnt != 4'hF)) begin
                        starve_d = starve_cnt + 4'd1;
                    end
                end
            end
            ISSUE_LCD: begin
                ram_en_o   = 1'b1;
                ram_addr_o = addr_q;
                state_d    = RESP_LCD;
            end
            ISSUE_CPU: begin
                ram_en_o    = 1'b1;
                ram_we_o    = we_q;
                ram_addr_o  = addr_q;
                ram_wdata_o = wdata_q;
                state_d     = RESP_CPU;
            end
            RESP_LCD: begin
                lcd_valid_o = 1'b1;
                lcd_data_o  = bus.ram_rdata;
                state_d     = IDLE;
            end
            RESP_CPU: begin
                cpu_ack_o   = 1'b1;
                cpu_rdata_o = we_q ? 8'h00 : bus.ram_rdata;
                state_d     = IDLE;
            end
            CPU_ERR: begin
                cpu_ack_o = 1'b1;
                cpu_err_o = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.lcd_data  = lcd_data_o;
    assign bus.lcd_valid = lcd_valid_o;
    assign bus.cpu_rdata = cpu_rdata_o;
    assign bus.cpu_ack   = cpu_ack_o;
    assign bus.cpu_err   = cpu_err_o;
    assign bus.ram_en    = ram_en_o;
    assign bus.ram_we    = ram_we_o;
    assign bus.ram_addr  = ram_addr_o;
    assign bus.ram_wdata = ram_wdata_o;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed bench for lcd_fb_arbiter with a 1-cycle-latency RAM model.
module tb_lcd_fb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_fb_arbiter_if bus ();

    lcd_fb_arbiter #(
        .RES_X(320), .RES_Y(240), .FB_BYTES(9600), .STARVE_MAX(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] mem [0:16383];

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] img(input int unsigned a);
        return 8'((a * 13) ^ (a >> 6));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lcd_n;
        logic        got;
        logic        en_seen;
        logic        err_v;
        logic [7:0]  rd_v;

        for (int unsigned i = 0; i < 16384; i++) mem[i] = img(i);
        bus.lcd_req   = 1'b0;
        bus.lcd_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick;
        chk("rst_strobes", {bus.lcd_valid, bus.cpu_ack, bus.cpu_err, bus.ram_en, bus.ram_we}, 0);
        chk("rst_data", {bus.lcd_data, bus.cpu_rdata, bus.ram_wdata}, 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_starve", 32'(dut.starve_cnt), 0);
        rst = 1'b0;
        tick;

        // Streaming LCD reads over the full framebuffer, one valid per 3 cycles
        bus.lcd_req  = 1'b1;
        bus.lcd_addr = 14'd0;
        for (int unsigned i = 0; i < 9600; i++) begin
            tick;
            chk("stream_issue", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.lcd_valid}, {1'b1, 1'b0, 14'(i), 1'b0});
            tick;
            chk($sformatf("stream_data[%0d]", i), {bus.lcd_valid, bus.lcd_data}, {1'b1, img(i)});
            if (i == 9599) bus.lcd_req = 1'b0;
            else           bus.lcd_addr = 14'(i + 1);
            tick;
            chk("stream_idle", {bus.lcd_valid, bus.ram_en}, 0);
        end

        // CPU write A5 to address 0, then read it back
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'd0; bus.cpu_wdata = 8'hA5;
        tick;
        chk("wr_issue", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_ack}, {1'b1, 1'b1, 14'd0, 8'hA5, 1'b0});
        tick;
        chk("wr_ack", {bus.cpu_ack, bus.cpu_err, bus.ram_en}, 3'b100);
        bus.cpu_req = 1'b0;
        tick;
        chk("wr_idle", {bus.cpu_ack, bus.ram_en}, 0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        tick;
        chk("rd_issue", {bus.ram_en, bus.ram_we, bus.ram_addr}, {1'b1, 1'b0, 14'd0});
        tick;
        chk("rd_ack", {bus.cpu_ack, bus.cpu_err, bus.cpu_rdata}, {1'b1, 1'b0, 8'hA5});
        bus.cpu_req = 1'b0;
        tick;

        // Simultaneous requests: LCD first, CPU at N+5
        bus.lcd_req = 1'b1; bus.lcd_addr = 14'd5;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd7;
        tick;
        chk("both_issue_lcd", {bus.ram_en, bus.ram_addr}, {1'b1, 14'd5});
        tick;
        chk("both_lcd_valid", {bus.lcd_valid, bus.lcd_data, bus.cpu_ack}, {1'b1, img(5), 1'b0});
        chk("both_starve1", 32'(dut.starve_cnt), 1);
        bus.lcd_req = 1'b0;
        tick;
        chk("both_idle", {bus.lcd_valid, bus.cpu_ack, bus.ram_en}, 0);
        tick;
        chk("both_issue_cpu", {bus.ram_en, bus.ram_addr}, {1'b1, 14'd7});
        tick;
        chk("both_cpu_ack", {bus.cpu_ack, bus.cpu_rdata}, {1'b1, img(7)});
        chk("both_starve0", 32'(dut.starve_cnt), 0);
        bus.cpu_req = 1'b0;
        tick;

        // Starvation limit: LCD re-requesting forever, CPU gets in after 15
        bus.lcd_req = 1'b1; bus.lcd_addr = 14'd100;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd200;
        lcd_n = 0; got = 1'b0;
        for (int unsigned c = 0; c < 100 && !got; c++) begin
            tick;
            if (bus.lcd_valid) begin
                lcd_n++;
                if (lcd_n == 15) chk("starve_at_max", 32'(dut.starve_cnt), 15);
            end
            if (bus.cpu_ack) begin
                got = 1'b1;
                chk("starve_cpu_rdata", 32'(bus.cpu_rdata), 32'(img(200)));
                chk("starve_cleared", 32'(dut.starve_cnt), 0);
            end
        end
        chk("starve_cpu_ack_seen", 32'(got), 1);
        chk("starve_lcd_grants", lcd_n, 15);
        bus.lcd_req = 1'b0; bus.cpu_req = 1'b0;
        tick;

        // Out-of-range CPU address: error ack, no RAM access
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd9600;
        got = 1'b0; en_seen = 1'b0; err_v = 1'b0; rd_v = 8'hFF;
        for (int unsigned c = 0; c < 6 && !got; c++) begin
            tick;
            en_seen |= bus.ram_en;
            if (bus.cpu_ack) begin
                got = 1'b1; err_v = bus.cpu_err; rd_v = bus.cpu_rdata;
                bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        tick;
        en_seen |= bus.ram_en;
        tick;
        en_seen |= bus.ram_en;
        chk("oob_ack", 32'(got), 1);
        chk("oob_err", 32'(err_v), 1);
        chk("oob_rdata", 32'(rd_v), 0);
        chk("oob_no_ram", 32'(en_seen), 0);
        chk("oob_err_idle", {bus.cpu_ack, bus.cpu_err}, 0);

        // Last in-range address is served normally
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd9599;
        tick;
        chk("last_issue", {bus.ram_en, bus.ram_addr}, {1'b1, 14'd9599});
        tick;
        chk("last_ack", {bus.cpu_ack, bus.cpu_err, bus.cpu_rdata}, {1'b1, 1'b0, img(9599)});
        bus.cpu_req = 1'b0;
        tick;

        // Reset during ISSUE_LCD with CPU pending (starve_cnt nonzero)
        bus.lcd_req = 1'b1; bus.lcd_addr = 14'd9;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd11;
        tick;
        chk("rst_lcd_issue", {bus.ram_en, bus.ram_addr}, {1'b1, 14'd9});
        chk("rst_lcd_starve1", 32'(dut.starve_cnt), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0; bus.lcd_req = 1'b0; bus.cpu_req = 1'b0;
        chk("rst_lcd_novalid", {bus.lcd_valid, bus.cpu_ack, bus.ram_en}, 0);
        chk("rst_lcd_starve0", 32'(dut.starve_cnt), 0);
        chk("rst_lcd_state", 32'(dut.state), 0);
        tick;
        chk("rst_lcd_quiet", {bus.lcd_valid, bus.cpu_ack, bus.ram_en}, 0);

        // Reset during ISSUE_CPU: access aborted, no ack
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'd3; bus.cpu_wdata = 8'h5A;
        tick;
        chk("rst_cpu_issue", {bus.ram_en, bus.ram_we}, 2'b11);
        rst = 1'b1;
        tick;
        rst = 1'b0; bus.cpu_req = 1'b0;
        chk("rst_cpu_noack", {bus.cpu_ack, bus.cpu_err, bus.ram_en}, 0);
        chk("rst_cpu_state", 32'(dut.state), 0);
        chk("rst_cpu_starve", 32'(dut.starve_cnt), 0);
        tick;
        chk("rst_cpu_noack2", {bus.cpu_ack, bus.ram_en}, 0);
        tick;
        chk("rst_cpu_noack3", {bus.cpu_ack, bus.ram_en}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
